// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE column read-out path.
//   LANE_W   : width of one signed partial-sum lane
//   LANES    : lanes per PE result word
//   PE_OUT_W : width of one PE result word
//   drain_state_t : drain FSM states
//   lane_slice()  : extracts lane k from a packed PE word (lane 0 in the LSBs)
package pe_array_pkg;

    localparam int LANE_W   = 14;
    localparam int LANES    = 4;
    localparam int PE_OUT_W = LANE_W * LANES;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    function automatic logic [LANE_W-1:0] lane_slice(input logic [PE_OUT_W-1:0] word,
                                                     input int unsigned         k);
        return word[k*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/pe_drain_lane_relu.sv
// Per-lane output conditioning on the drain read path.
// Optional macro: PE_DRAIN_RELU_EN -- when defined, negative lanes clamp to 0;
// otherwise the lane passes through unchanged. Purely combinational.
//   lane_in  : signed lane from the selected buffer row
//   lane_out : conditioned lane toward the m_data register
module pe_drain_lane_relu
    import pe_array_pkg::*;
(
    input  logic signed [LANE_W-1:0] lane_in,
    output logic signed [LANE_W-1:0] lane_out
);

`ifdef PE_DRAIN_RELU_EN
    // Two's-complement sign bit set means negative: clamp to zero.
    function automatic logic signed [LANE_W-1:0] relu_clamp(input logic signed [LANE_W-1:0] x);
        return x[LANE_W-1] ? '0 : x;
    endfunction

    assign lane_out = relu_clamp(lane_in);
`else
    assign lane_out = lane_in;
`endif

endmodule

// File: rtl/pe_out_drain.sv
// Read-out end of a systolic PE column. Captures all ROWS packed PE results in
// one cycle, pulses acc_clear so the column can start the next tile, then
// drains one row per valid/ready handshake. A capture arriving on the cycle of
// the last-row handshake reloads seamlessly; any other capture during a drain
// is dropped and flagged on the sticky overrun output.
// Optional macro: PE_DRAIN_RELU_EN (per-lane ReLU clamp on the read path).
//   clk, reset     : clock, synchronous active-high reset
//   capture        : one-cycle request to latch pe_out
//   pe_out         : ROWS flattened PE words, row r at [r*PE_OUT_W +: PE_OUT_W]
//   acc_clear      : one-cycle pulse to the column accumulators
//   busy           : high while draining
//   m_valid/m_ready: output stream handshake
//   m_data, m_row  : current row word and its index
//   m_last         : marks the final row of a tile
//   overrun        : sticky dropped-capture flag, cleared by overrun_clr
module pe_out_drain
    import pe_array_pkg::*;
#(
    parameter  int ROWS  = 8,
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [ROWS*PE_OUT_W-1:0] pe_out,
    output logic                     acc_clear,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [PE_OUT_W-1:0]      m_data,
    output logic [ROW_W-1:0]         m_row,
    output logic                     m_last,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    drain_state_t state, state_nxt;

    logic [PE_OUT_W-1:0]           row_buf [ROWS];
    logic                          hs, last_row, last_hs, accept, drop;
    logic [ROW_W-1:0]              nxt_row;
    logic [PE_OUT_W-1:0]           src_word;
    logic [LANES-1:0][LANE_W-1:0]  nxt_lanes;
    logic [PE_OUT_W-1:0]           nxt_word;

    assign hs       = m_valid && m_ready;
    assign last_row = (m_row == ROW_W'(ROWS-1));
    assign last_hs  = hs && last_row;
    // A capture is taken when idle, or on the last-row handshake (no bubble).
    assign accept   = capture && ((state == IDLE) || last_hs);
    assign drop     = capture && (state == DRAIN) && !last_hs;
    assign nxt_row  = last_row ? '0 : m_row + 1'b1;

    // Word to present next: row 0 of the incoming tile on a load, otherwise
    // the following buffered row. Conditioning happens before the register so
    // it costs no extra cycle.
    assign src_word = accept ? pe_out[PE_OUT_W-1:0] : row_buf[nxt_row];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_drain_lane_relu u_lane (
            .lane_in  (lane_slice(src_word, k)),
            .lane_out (nxt_lanes[k])
        );
    end

    assign nxt_word = nxt_lanes;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)              state_nxt = DRAIN;
            DRAIN:   if (last_hs && !capture) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy    = (state == DRAIN);
        m_valid = busy;
        m_last  = m_valid && last_row;
    end

    // Capture buffer, row pointer, presented word and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_clear <= 1'b0;
            overrun   <= 1'b0;
            m_row     <= '0;
            m_data    <= '0;
            for (int r = 0; r < ROWS; r++) row_buf[r] <= '0;
        end else begin
            acc_clear <= accept;
            // A dropped capture outranks a simultaneous clear.
            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;

            if (accept) begin
                for (int r = 0; r < ROWS; r++) row_buf[r] <= pe_out[r*PE_OUT_W +: PE_OUT_W];
                m_row  <= '0;
                m_data <= nxt_word;
            end else if (hs) begin
                m_row <= nxt_row;
                if (!last_row) m_data <= nxt_word;
            end
        end
    end

endmodule

// File: tb/tb_pe_out_drain.sv
// Self-checking bench for pe_out_drain: directed sequences, a lane table and
// randomized traffic, all compared per cycle against a queue-based model.
module tb_pe_out_drain;
    import pe_array_pkg::*;

    localparam int ROWS  = 8;
    localparam int ROW_W = $clog2(ROWS);
    localparam int TW    = ROWS*PE_OUT_W;

    logic                clk = 1'b0;
    logic                reset, capture, m_ready, overrun_clr;
    logic [TW-1:0]       pe_out;
    logic                acc_clear, busy, m_valid, m_last, overrun;
    logic [PE_OUT_W-1:0] m_data;
    logic [ROW_W-1:0]    m_row;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: queue of words still to be delivered for the current tile.
    logic [PE_OUT_W-1:0] exp_q[$];
    logic                exp_clr = 1'b0;
    logic                exp_ov  = 1'b0;

    always #5 clk = ~clk;

    pe_out_drain #(.ROWS(ROWS)) dut (
        .clk(clk), .reset(reset), .capture(capture), .pe_out(pe_out),
        .acc_clear(acc_clear), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_row(m_row), .m_last(m_last), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    typedef struct {
        logic [PE_OUT_W-1:0] word_in;
        logic [PE_OUT_W-1:0] word_exp;
    } lane_vec_t;

    function automatic logic [PE_OUT_W-1:0] mk(input logic [13:0] l0, input logic [13:0] l1,
                                               input logic [13:0] l2, input logic [13:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [PE_OUT_W-1:0] relu_ref(input logic [PE_OUT_W-1:0] w);
        logic [PE_OUT_W-1:0] o;
        o = w;
`ifdef PE_DRAIN_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            logic signed [LANE_W-1:0] v;
            v = w[k*LANE_W +: LANE_W];
            if (v < $signed(14'sd0)) o[k*LANE_W +: LANE_W] = '0;
        end
`endif
        return o;
    endfunction

    function automatic logic [TW-1:0] ramp_tile();
        logic [TW-1:0] t;
        for (int r = 0; r < ROWS; r++)
            t[r*PE_OUT_W +: PE_OUT_W] = mk(14'(r), 14'(r+1), 14'(r+2), 14'(r+3));
        return t;
    endfunction

    function automatic logic [TW-1:0] fill_tile(input logic [PE_OUT_W-1:0] w);
        logic [TW-1:0] t;
        for (int r = 0; r < ROWS; r++) t[r*PE_OUT_W +: PE_OUT_W] = w;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare current outputs to the model, drive inputs, advance.
    task automatic cyc(input logic cap, input logic rdy, input logic clr, input logic rst);
        int  sz;
        logic was_empty, hsm, lastb, acc;
        sz = exp_q.size();
        chk("m_valid",   64'(m_valid),   64'(sz > 0));
        chk("busy",      64'(busy),      64'(sz > 0));
        chk("m_last",    64'(m_last),    64'(sz == 1));
        chk("m_row",     64'(m_row),     (sz > 0) ? 64'(ROWS - sz) : 64'd0);
        if (sz > 0) chk("m_data", 64'(m_data), 64'(exp_q[0]));
        chk("acc_clear", 64'(acc_clear), 64'(exp_clr));
        chk("overrun",   64'(overrun),   64'(exp_ov));

        capture = cap; m_ready = rdy; overrun_clr = clr; reset = rst;

        if (rst) begin
            exp_q.delete();
            exp_clr = 1'b0;
            exp_ov  = 1'b0;
        end else begin
            was_empty = (sz == 0);
            hsm   = !was_empty && rdy;
            lastb = hsm && (sz == 1);
            if (hsm) void'(exp_q.pop_front());
            acc = cap && (was_empty || lastb);
            if (acc)
                for (int r = 0; r < ROWS; r++) exp_q.push_back(relu_ref(pe_out[r*PE_OUT_W +: PE_OUT_W]));
            exp_clr = acc;
            if (cap && !acc) exp_ov = 1'b1;
            else if (clr)    exp_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    lane_vec_t tbl[4];
    logic [TW-1:0] tile_a;
    logic [1:0] rpat [4];

    initial begin
        reset = 1'b1; capture = 1'b0; m_ready = 1'b0; overrun_clr = 1'b0; pe_out = '0;
        rpat[0] = 2'd1; rpat[1] = 2'd0; rpat[2] = 2'd0; rpat[3] = 2'd1;

        tbl[0].word_in = mk(14'h3FFF, 14'd8191, 14'h2000, 14'd0);
        tbl[1].word_in = mk(14'd5, 14'h3FFB, 14'd100, 14'h3F9C);
        tbl[2].word_in = mk(14'd0, 14'd0, 14'd0, 14'd0);
        tbl[3].word_in = mk(14'd8191, 14'd1, 14'h3FFF, 14'd1);
`ifdef PE_DRAIN_RELU_EN
        tbl[0].word_exp = mk(14'd0, 14'd8191, 14'd0, 14'd0);
        tbl[1].word_exp = mk(14'd5, 14'd0, 14'd100, 14'd0);
        tbl[2].word_exp = mk(14'd0, 14'd0, 14'd0, 14'd0);
        tbl[3].word_exp = mk(14'd8191, 14'd1, 14'd0, 14'd1);
`else
        for (int i = 0; i < 4; i++) tbl[i].word_exp = tbl[i].word_in;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(0, 0, 0, 1);
        chk("m_data_reset", 64'(m_data), 64'd0);

        // 1: ramp tile, ready held high
        tile_a = ramp_tile();
        pe_out = tile_a;
        cyc(1, 1, 0, 0);
        repeat (10) cyc(0, 1, 0, 0);

        // 2: ready toggling 1,0,0,1
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, rpat[i % 4][0], 0, 0);

        // 3: back-to-back capture on the row-7 handshake with inverted data
        cyc(1, 1, 0, 0);
        repeat (7) cyc(0, 1, 0, 0);
        chk("row7_before_b2b", 64'(m_row), 64'd7);
        pe_out = ~tile_a;
        cyc(1, 1, 0, 0);
        chk("b2b_row0_data", 64'(m_data), 64'(relu_ref(~tile_a[PE_OUT_W-1:0])));
        chk("b2b_acc_clear", 64'(acc_clear), 64'd1);
        repeat (9) cyc(0, 1, 0, 0);

        // 4: captures dropped mid-drain; clear coinciding with a drop
        pe_out = tile_a;
        cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        pe_out = ~tile_a;
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 0);
        chk("overrun_set_wins", 64'(overrun), 64'd1);
        cyc(0, 1, 1, 0);
        repeat (6) cyc(0, 1, 0, 0);

        // 5: reset at row 5, then a fresh drain
        pe_out = tile_a;
        cyc(1, 1, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        chk("row5_before_reset", 64'(m_row), 64'd5);
        cyc(0, 1, 0, 1);
        cyc(1, 1, 0, 0);
        repeat (9) cyc(0, 1, 0, 0);

        // 6: lane table
        for (int i = 0; i < 4; i++) begin
            pe_out = fill_tile(tbl[i].word_in);
            cyc(1, 1, 0, 0);
            chk("lane_tbl", 64'(m_data), 64'(tbl[i].word_exp));
            repeat (8) cyc(0, 1, 0, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < TW; j += 32) pe_out[j +: 32] = $urandom;
            cyc(($urandom % 6) == 0, ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 150) == 0);
        end
        cyc(0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_out_drain.md
Name: pe_out_drain

Overview:
- Read-out end of the systolic PE column: captures the packed MAC results of ROWS processing elements in one cycle.
- Drains the captured results one row per handshake over a valid/ready stream toward the output buffer / requantizer.
- Pulses an accumulator-clear to the column so the PEs can start the next tile while the drain runs.
- Sits at the bottom edge of each PE column, opposite the operand feeders.

Parameters:
- ROWS, 8, number of PEs in the column (>=2).
- LANE_W, 14, width of one signed partial-sum lane (10-bit product width + 4 headroom).
- LANES, 4, lanes per PE word (2 parallel pixels x 2 parallel weights).
- PE_OUT_W, LANE_W*LANES (56), width of one PE result word.
- ROW_W, $clog2(ROWS), row index width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- capture, input, 1, one-cycle request to latch all PE results.
- pe_out, input, ROWS*PE_OUT_W, flattened PE results; row r occupies bits [r*PE_OUT_W +: PE_OUT_W].
- acc_clear, output, 1, one-cycle pulse to the PE column accumulators.
- busy, output, 1, high while in DRAIN.
- m_valid, output, 1, stream valid.
- m_ready, input, 1, stream ready.
- m_data, output, PE_OUT_W, current row word, lane k at [k*LANE_W +: LANE_W].
- m_row, output, ROW_W, row index of m_data.
- m_last, output, 1, high with m_valid when m_row == ROWS-1.
- overrun, output, 1, sticky; a capture was dropped.
- overrun_clr, input, 1, clears overrun.

Behaviour:
- Reset values: state IDLE; acc_clear, busy, m_valid, m_last and overrun = 0; m_row = 0; capture buffer = 0; m_data = 0.
- FSM states: IDLE, DRAIN.
- IDLE with capture=1:
  - Latch all ROWS words into the buffer.
  - Next cycle: state DRAIN, m_valid=1, m_row=0, acc_clear=1 for exactly that cycle.
  - Latency: capture to first m_valid is 1 cycle.
- DRAIN:
  - m_data = buffer[m_row], registered. It is stable while m_valid && !m_ready.
  - Handshake occurs when m_valid && m_ready. On a handshake with m_row < ROWS-1, m_row increments; one row per cycle is sustained when m_ready is held high.
  - Handshake at m_row == ROWS-1: go to IDLE with m_valid=0, m_row=0.
- Back-to-back: capture in the same cycle as the last-row handshake is accepted.
  - The buffer reloads and state stays DRAIN with m_row=0.
  - acc_clear pulses next cycle; there is no bubble.
- Capture during DRAIN other than that cycle:
  - The capture is ignored and the buffer is untouched.
  - overrun is set next cycle.
  - acc_clear is not pulsed.
- overrun:
  - Set by a dropped capture, cleared by overrun_clr.
  - If both occur in the same cycle, set wins.
- m_valid never deasserts without a handshake, except on reset.
- Reset mid-drain: the outstanding word is abandoned, all outputs go to reset values, and no acc_clear is issued.
- busy is high exactly when state == DRAIN.
- m_last = m_valid && (m_row == ROWS-1).
- Lanes are opaque signed two's-complement; no arithmetic is done in the default build.

Optional Feature:
- Macro PE_DRAIN_RELU_EN.
- Defined: each lane of m_data is clamped to 0 if negative (lane MSB=1), otherwise passed. The clamp is applied on the buffer read path and adds no latency.
- Undefined: lanes pass unchanged.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package pe_array_pkg holds LANE_W, LANES, PE_OUT_W, the drain state enum {IDLE, DRAIN}, and the lane slice helper function.
- One sub-module, pe_drain_lane_relu: one LANE_W lane in, one out. It is a pass-through when the macro is off and is instantiated LANES times.

Test Plan:
1. Reset, then capture with row r lanes = {r, r+1, r+2, r+3}, ROWS=8, m_ready=1.
   - acc_clear pulses once, one cycle after capture.
   - Rows 0..7 appear in 8 consecutive cycles.
   - m_last only at row 7; then IDLE with busy=0.
2. Same load with m_ready toggling 1,0,0,1 repeatedly.
   - m_data and m_row are held during stalls.
   - Exactly 8 handshakes in order with no duplicates.
3. Second capture asserted in the same cycle as the row-7 handshake, with new data = ~old.
   - No idle cycle.
   - Row 0 of the new data follows immediately.
   - A second acc_clear pulse occurs.
4. Capture at row 3 of an ongoing drain.
   - overrun=1 next cycle; the drain continues with the original data.
   - overrun_clr in the same cycle as another dropped capture leaves overrun=1.
5. Reset asserted at row 5 with m_valid=1.
   - Next cycle m_valid=0, m_row=0, busy=0, acc_clear=0.
   - A following capture drains from row 0.
6. Lane values {-1, 8191, -8192, 0} (with PE_DRAIN_RELU_EN): output {0, 8191, 0, 0}. Without the macro: output unchanged.
